// File: rtl/mux2a1_cuatrobits_pkg.sv
// Constants and types shared by the 2-to-1 transmit serializer and its 1-to-2 receive demux.
package mux2a1_cuatrobits_pkg;

    localparam int DATA_W_DEF     = 4;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int NUM_LANES      = 2;

    // The receive side starts on lane 0 and toggles on every valid word.
    localparam logic RX_FIRST_LANE = 1'b0;

    typedef logic [1:0] count_t;
    typedef logic       lane_idx_t;

    function automatic logic count_has_room(input count_t cnt, input int depth);
        return int'(cnt) < depth;
    endfunction

endpackage

// File: rtl/mux2a1_cuatrobits_tx_lane_fifo2.sv
// Two-entry per-lane FIFO; push and pop may occur in the same cycle.
module lane_fifo2
    import mux2a1_cuatrobits_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output count_t            count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    count_t            count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        do_push  = push && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        // 1-bit pointers wrap modulo 2 on their own
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + count_t'(do_push) - count_t'(do_pop);
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mux2a1_cuatrobits_tx.sv
// 2-to-1 serializer: buffers two input lanes and emits words in strict lane0/lane1 alternation.
module mux2a1_cuatrobits_tx
    import mux2a1_cuatrobits_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in0,
    output logic              ready_in0,
    input  logic              valid_in1,
    input  logic [DATA_W-1:0] data_in1,
    output logic              ready_in1,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              lane_out,
    output logic              idle
);

    logic              lane_valid [NUM_LANES];
    logic [DATA_W-1:0] lane_data  [NUM_LANES];
    logic              lane_ready [NUM_LANES];
    logic              lane_pop   [NUM_LANES];
    count_t            lane_count [NUM_LANES];
    logic [DATA_W-1:0] lane_head  [NUM_LANES];

    lane_idx_t         sel_q, sel_d;
    logic              valid_out_q, valid_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    lane_idx_t         lane_out_q, lane_out_d;
    logic              serve;

    assign lane_valid[0] = valid_in0;
    assign lane_valid[1] = valid_in1;
    assign lane_data[0]  = data_in0;
    assign lane_data[1]  = data_in1;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_ready[gi] = !reset && count_has_room(lane_count[gi], FIFO_DEPTH);
            assign lane_pop[gi]   = serve && (sel_q == lane_idx_t'(gi));

            lane_fifo2 #(
                .DATA_W(DATA_W)
            ) u_fifo (
                .clk_4f   (clk_4f),
                .reset    (reset),
                .push     (lane_valid[gi] && lane_ready[gi]),
                .push_data(lane_data[gi]),
                .pop      (lane_pop[gi]),
                .count    (lane_count[gi]),
                .head     (lane_head[gi])
            );
        end
    endgenerate

    // Only the selected lane may be served; the other waits even if it holds data.
    always_comb begin
        serve       = (lane_count[sel_q] != 2'd0);
        valid_out_d = serve;
        data_out_d  = data_out_q;
        lane_out_d  = lane_out_q;
        sel_d       = sel_q;
        if (serve) begin
            data_out_d = lane_head[sel_q];
            lane_out_d = sel_q;
            sel_d      = ~sel_q;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            sel_q       <= RX_FIRST_LANE;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            lane_out_q  <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            lane_out_q  <= lane_out_d;
        end
    end

    assign ready_in0 = lane_ready[0];
    assign ready_in1 = lane_ready[1];
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign lane_out  = lane_out_q;
    assign idle      = (lane_count[0] == 2'd0) && (lane_count[1] == 2'd0);

endmodule

// File: tb/tb_mux2a1_cuatrobits_tx.sv
// Scoreboard bench: the k-th output word must be the next accepted word of lane k mod 2.
module tb_mux2a1_cuatrobits_tx;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in0 = 1'b1, valid_in1 = 1'b1;
    logic [3:0] data_in0 = 4'h0, data_in1 = 4'h0;
    logic       ready_in0, ready_in1, valid_out, lane_out, idle;
    logic [3:0] data_out;

    int checks = 0;
    int passes = 0;

    // Reference model: per-lane queues of accepted words, occupancy, next lane to be served.
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    int         occ0 = 0, occ1 = 0;
    bit         next_lane = 1'b0;
    bit         exp_valid = 1'b0;
    logic [3:0] last_d = 4'h0;
    bit         last_l = 1'b0;
    bit         seen_rst = 1'b0;

    mux2a1_cuatrobits_tx dut (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .valid_in0(valid_in0),
        .data_in0 (data_in0),
        .ready_in0(ready_in0),
        .valid_in1(valid_in1),
        .data_in1 (data_in1),
        .ready_in1(ready_in1),
        .valid_out(valid_out),
        .data_out (data_out),
        .lane_out (lane_out),
        .idle     (idle)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: evaluates what the preceding rising edge should have produced.
    always @(negedge clk_4f) begin
        logic [3:0] exp_d;
        if (reset) seen_rst = 1'b1;
        if (seen_rst) begin
            if (reset) begin
                chk("rst_valid_out", int'(valid_out), 0);
                chk("rst_data_out", int'(data_out), 0);
                chk("rst_lane_out", int'(lane_out), 0);
                q0.delete(); q1.delete();
                occ0 = 0; occ1 = 0;
                next_lane = 1'b0;
                last_d = 4'h0; last_l = 1'b0;
            end else begin
                chk("valid_out", int'(valid_out), int'(exp_valid));
                if (exp_valid) begin
                    if (next_lane == 1'b0) begin exp_d = q0.pop_front(); occ0--; end
                    else begin exp_d = q1.pop_front(); occ1--; end
                    chk("data_out", int'(data_out), int'(exp_d));
                    chk("lane_out", int'(lane_out), int'(next_lane));
                    $display("out lane=%0d data=%h", lane_out, data_out);
                    last_d = exp_d; last_l = next_lane;
                    next_lane = ~next_lane;
                end else begin
                    chk("hold_data_out", int'(data_out), int'(last_d));
                    chk("hold_lane_out", int'(lane_out), int'(last_l));
                end
            end
            chk("ready_in0", int'(ready_in0), int'(!reset && occ0 < 2));
            chk("ready_in1", int'(ready_in1), int'(!reset && occ1 < 2));
            chk("idle", int'(idle), int'(occ0 == 0 && occ1 == 0));
            exp_valid = (next_lane == 1'b0) ? (occ0 > 0) : (occ1 > 0);
        end
    end

    // Drives one cycle of stimulus and records accepted words in the scoreboard.
    task automatic drive(input bit v0, input logic [3:0] d0, input bit v1, input logic [3:0] d1,
                         input bit rst, output bit a0, output bit a1);
        @(negedge clk_4f);
        #1;
        reset = rst; valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1;
        a0 = !rst && v0 && occ0 < 2;
        a1 = !rst && v1 && occ1 < 2;
        if (a0) begin q0.push_back(d0); occ0++; end
        if (a1) begin q1.push_back(d1); occ1++; end
    endtask

    task automatic step(input bit v0, input logic [3:0] d0, input bit v1, input logic [3:0] d1,
                        input bit rst);
        bit a0, a1;
        drive(v0, d0, v1, d1, rst, a0, a1);
    endtask

    initial begin
        bit         a0, a1;
        int         sent0, sent1, guard;
        logic [3:0] w0, w1;

        // Reset held with both lanes offering words
        repeat (3) step(1, 4'h7, 1, 4'h8, 1);
        step(0, 0, 0, 0, 0);

        // Both lanes fed continuously
        step(1, 4'h1, 1, 4'hA, 0);
        step(1, 4'h2, 1, 4'hB, 0);
        step(1, 4'h3, 1, 4'hC, 0);
        repeat (8) step(0, 0, 0, 0, 0);

        // Lane 1 only: fills and stalls, then one lane 0 word releases 9,5
        step(0, 0, 1, 4'h5, 0);
        step(0, 0, 1, 4'h6, 0);
        step(0, 0, 1, 4'h7, 0);
        step(1, 4'h9, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Push while popping a lane-0 word held at count 1
        step(1, 4'h1, 0, 0, 0);
        step(1, 4'hE, 1, 4'h2, 0);
        step(0, 0, 1, 4'h4, 0);
        repeat (4) step(0, 0, 0, 0, 0);

        // Load both lanes, reset mid-stream, then lane1 word before lane0 word
        step(0, 0, 1, 4'hD, 0);
        step(0, 0, 1, 4'hD, 0);
        step(1, 4'hF, 1, 4'hD, 0);
        step(1, 4'hF, 1, 4'hD, 1);
        step(0, 0, 1, 4'h3, 0);
        step(1, 4'h4, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);

        // Random traffic: 200 words per lane, each word held until accepted
        step(0, 0, 0, 0, 1);
        sent0 = 0; sent1 = 0; guard = 0;
        w0 = 4'($urandom); w1 = 4'($urandom);
        while ((sent0 < 200 || sent1 < 200) && guard < 5000) begin
            drive(sent0 < 200 && $urandom_range(9, 0) < 8, w0,
                  sent1 < 200 && $urandom_range(9, 0) < 8, w1, 0, a0, a1);
            if (a0) begin sent0++; w0 = 4'($urandom); end
            if (a1) begin sent1++; w1 = 4'($urandom); end
            guard++;
        end
        chk("random_feed_done", int'(sent0 == 200 && sent1 == 200), 1);

        guard = 0;
        while ((occ0 != 0 || occ1 != 0) && guard < 50) begin
            step(0, 0, 0, 0, 0);
            guard++;
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk_4f);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
